// File: rtl/eth_pcs_tx_gearbox_flex_pkg.sv
// Shared 10GBASE-R PCS block constants and gearbox sizing helpers.
package eth_pcs_params;

  localparam int W_SYNC     = 2;
  localparam int W_BLK_DATA = 64;
  localparam int W_BLK      = W_SYNC + W_BLK_DATA;

  // Supported PMA word widths, one byte per entry.
  localparam int                          N_PMA_OPTS = 3;
  localparam logic [N_PMA_OPTS*8-1:0]     PMA_OPTS   = {8'd64, 8'd32, 8'd16};

  function automatic bit is_legal_pma(input int w_pma);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < N_PMA_OPTS; k++) begin
      if (int'(PMA_OPTS[k*8 +: 8]) == w_pma) ok = 1'b1;
    end
    return ok;
  endfunction

  // Worst-case occupancy is W_PMA-1 leftover bits plus one whole block.
  function automatic int calc_w_buf(input int w_pma);
    return w_pma + W_BLK - 1;
  endfunction

  function automatic int calc_w_fill(input int w_pma);
    return $clog2(w_pma + W_BLK);
  endfunction

endpackage

// File: rtl/eth_pcs_tx_gearbox_flex.sv
// 66b -> W_PMA-bit transmit gearbox: whole blocks in under valid/ready,
// one PMA word out per cycle whenever enough bits are buffered.
module eth_pcs_tx_gearbox_flex
  import eth_pcs_params::*;
#(
  parameter  int W_PMA  = 32,
  localparam int W_BUF  = calc_w_buf(W_PMA),
  localparam int W_FILL = calc_w_fill(W_PMA)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_blk_valid,
  output logic                  o_blk_ready,
  input  logic [W_SYNC-1:0]     i_sync_hdr,
  input  logic [W_BLK_DATA-1:0] i_blk_data,
  output logic                  o_pma_valid,
  output logic [W_PMA-1:0]      o_pma_data,
  output logic [W_FILL-1:0]     o_fill,
  output logic                  o_underflow
);

  if (!is_legal_pma(W_PMA)) begin : g_illegal_w_pma
    $error("eth_pcs_tx_gearbox_flex: W_PMA must be 16, 32 or 64");
  end

  logic [W_BUF-1:0]  r_buf;
  logic [W_FILL-1:0] r_fill;
  logic              r_started;
  logic              r_uflow;

  logic              w_emit;
  logic [W_FILL-1:0] w_rem;
  logic              w_ready;
  logic              w_accept;
  logic              w_uflow;
  logic [W_BUF-1:0]  w_buf_nxt;
  logic [W_FILL-1:0] w_fill_nxt;

  assign w_emit   = (r_fill >= W_FILL'(W_PMA));
  assign w_rem    = w_emit ? (r_fill - W_FILL'(W_PMA)) : r_fill;
  // Ready depends only on registered occupancy, so upstream sees no
  // combinational loop through its own valid.
  assign w_ready  = (w_rem < W_FILL'(W_PMA));
  assign w_accept = i_blk_valid & w_ready;
  assign w_uflow  = r_uflow | (r_started & ~w_emit);

  // Drain the emitted word, then splice an accepted block in right after the
  // remaining bits (header first, LSB-first).
  always_comb begin
    w_buf_nxt  = w_emit ? (r_buf >> W_PMA) : r_buf;
    w_fill_nxt = w_rem;
    if (w_accept) begin
      w_buf_nxt  = w_buf_nxt | (W_BUF'({i_blk_data, i_sync_hdr}) << w_rem);
      w_fill_nxt = w_rem + W_FILL'(W_BLK);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buf     <= '0;
      r_fill    <= '0;
      r_started <= 1'b0;
      r_uflow   <= 1'b0;
    end else begin
      r_buf     <= w_buf_nxt;
      r_fill    <= w_fill_nxt;
      r_started <= r_started | w_accept;
      r_uflow   <= w_uflow;
    end
  end

  assign o_blk_ready = w_ready;
  assign o_pma_valid = w_emit;
  assign o_pma_data  = w_emit ? r_buf[W_PMA-1:0] : '0;
  assign o_fill      = r_fill;
  // A starved cycle is flagged in the same cycle it occurs and then held.
  assign o_underflow = w_uflow;

endmodule
